// File: rtl/sparc_alu_pkg.sv
// Shared SPARC integer-unit definitions: op3 codes, mul/div sequencer state encoding
// and small decode helpers used by the ALU, decode and the mul/div sequencer.
package sparc_alu_pkg;

    localparam logic [5:0] OP3_UMUL   = 6'h0A;
    localparam logic [5:0] OP3_SMUL   = 6'h0B;
    localparam logic [5:0] OP3_UMULCC = 6'h1A;
    localparam logic [5:0] OP3_SMULCC = 6'h1B;
    localparam logic [5:0] OP3_UDIV   = 6'h0E;
    localparam logic [5:0] OP3_SDIV   = 6'h0F;
    localparam logic [5:0] OP3_UDIVCC = 6'h1E;
    localparam logic [5:0] OP3_SDIVCC = 6'h1F;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } md_state_e;

    typedef enum logic [1:0] {
        MD_MUL = 2'd0,
        MD_DIV = 2'd1,
        MD_DBZ = 2'd2,
        MD_ILL = 2'd3
    } md_kind_e;

    function automatic md_kind_e md_decode(input logic [5:0] op3, input logic [31:0] divisor);
        md_kind_e k;
        case (op3)
            OP3_UMUL, OP3_SMUL, OP3_UMULCC, OP3_SMULCC: k = MD_MUL;
            OP3_UDIV, OP3_SDIV, OP3_UDIVCC, OP3_SDIVCC: k = (divisor == 32'd0) ? MD_DBZ : MD_DIV;
            default:                                    k = MD_ILL;
        endcase
        return k;
    endfunction

    function automatic logic [31:0] mag32(input logic [31:0] x, input logic sgn);
        return (sgn && x[31]) ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/muldiv_addsub.sv
// 33-bit add/subtract step shared by the shift-add multiplier and restoring divider.
// For subtract, carry_o=1 means no borrow (a_i >= b_i).
module muldiv_addsub (
    input  logic [32:0] a_i,
    input  logic [32:0] b_i,
    input  logic        sub_i,
    output logic [32:0] sum_o,
    output logic        carry_o
);

    logic [33:0] res;

    assign res              = {1'b0, a_i} + {1'b0, (sub_i ? ~b_i : b_i)} + {33'd0, sub_i};
    assign {carry_o, sum_o} = res;

endmodule

// File: rtl/muldiv_seq.sv
// Sequential SPARC multiply/divide unit: iterates on operand magnitudes, then
// applies sign correction and divide saturation before committing results.
module muldiv_seq
    import sparc_alu_pkg::*;
#(
    parameter int MUL_STEPS = 32,
    parameter int DIV_STEPS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        flush,
    input  logic [5:0]  opcode,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic [31:0] y_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] rd_out,
    output logic [31:0] y_out,
    output logic [3:0]  icc_out,
    output logic        y_we,
    output logic        icc_we,
    output logic        division_by_zero
);
    // IDLE wait start | CALC iterate | FIX sign fix/saturate | DONE commit outputs
    localparam int MAX_STEPS = (DIV_STEPS > MUL_STEPS) ? DIV_STEPS : MUL_STEPS;
    localparam int CNT_W     = $clog2(MAX_STEPS) + 1;

    md_state_e        state_q, state_d;
    md_kind_e         kind_q, kind_d, start_kind;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sgn_q, sgn_d, cc_q, cc_d, neg_q, neg_d, ovf_q, ovf_d;
    logic [31:0]      acc_q, acc_d, opnd_q, opnd_d;
    logic [63:0]      sh_q, sh_d;
    logic [31:0]      rd_q, rd_d, y_q, y_d;
    logic [3:0]       icc_q, icc_d;
    logic             done_q, done_d, y_we_q, y_we_d, icc_we_q, icc_we_d, dbz_q, dbz_d;

    logic [32:0] as_a, as_b, as_sum, mul_sum;
    logic        as_sub, as_co, accept, div_ovf;
    logic [63:0] dvd, prod;
    logic [31:0] div_res;

    assign accept     = (state_q == ST_IDLE) && start && !flush;
    assign start_kind = md_decode(opcode, rs2);

    // Divide shifts the next dividend bit into the partial remainder before the trial subtract.
    assign as_sub = (kind_q == MD_DIV);
    assign as_a   = as_sub ? {acc_q, sh_q[63]} : {1'b0, acc_q};
    assign as_b   = {1'b0, opnd_q};

    muldiv_addsub u_addsub (
        .a_i     (as_a),
        .b_i     (as_b),
        .sub_i   (as_sub),
        .sum_o   (as_sum),
        .carry_o (as_co)
    );

    assign mul_sum = sh_q[0] ? as_sum : {1'b0, acc_q};
    assign dvd     = {y_in, rs1};
    assign prod    = neg_q ? (~{acc_q, sh_q[31:0]} + 64'd1) : {acc_q, sh_q[31:0]};

    always_comb begin
        div_ovf = 1'b0;
        div_res = sh_q[31:0];
        if (!sgn_q) begin
            div_ovf = |sh_q[63:32];
            if (div_ovf) div_res = 32'hFFFF_FFFF;
        end else if (!neg_q) begin
            div_ovf = |sh_q[63:31];
            if (div_ovf) div_res = 32'h7FFF_FFFF;
        end else begin
            div_ovf = (sh_q > 64'h0000_0000_8000_0000);
            div_res = div_ovf ? 32'h8000_0000 : (~sh_q[31:0] + 32'd1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = (start_kind == MD_MUL || start_kind == MD_DIV) ? ST_CALC : ST_DONE;
            ST_CALC: if (cnt_q == '0) state_d = ST_FIX;
            ST_FIX:  state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (flush) state_d = ST_IDLE;
    end

    always_comb begin
        kind_d   = kind_q;
        cnt_d    = cnt_q;
        sgn_d    = sgn_q;
        cc_d     = cc_q;
        neg_d    = neg_q;
        ovf_d    = ovf_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        sh_d     = sh_q;
        rd_d     = rd_q;
        y_d      = y_q;
        icc_d    = icc_q;
        done_d   = 1'b0;
        y_we_d   = 1'b0;
        icc_we_d = 1'b0;
        dbz_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    kind_d = start_kind;
                    sgn_d  = opcode[0];
                    cc_d   = opcode[4];
                    acc_d  = '0;
                    opnd_d = mag32(rs2, opcode[0]);
                    if (start_kind == MD_DIV) begin
                        neg_d = opcode[0] & (y_in[31] ^ rs2[31]);
                        sh_d  = (opcode[0] && y_in[31]) ? (~dvd + 64'd1) : dvd;
                        cnt_d = CNT_W'(DIV_STEPS - 1);
                    end else begin
                        neg_d = opcode[0] & (rs1[31] ^ rs2[31]);
                        sh_d  = {32'd0, mag32(rs1, opcode[0])};
                        cnt_d = CNT_W'(MUL_STEPS - 1);
                    end
                end
            end
            ST_CALC: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (kind_q == MD_DIV) begin
                    sh_d  = {sh_q[62:0], as_co};
                    acc_d = as_co ? as_sum[31:0] : as_a[31:0];
                end else begin
                    acc_d       = mul_sum[32:1];
                    sh_d[31:0]  = {mul_sum[0], sh_q[31:1]};
                end
            end
            ST_FIX: begin
                if (kind_q == MD_DIV) begin
                    sh_d[31:0] = div_res;
                    ovf_d      = div_ovf;
                end else begin
                    acc_d      = prod[63:32];
                    sh_d[31:0] = prod[31:0];
                end
            end
            ST_DONE: begin
                if (!flush) begin
                    done_d = 1'b1;
                    case (kind_q)
                        MD_MUL: begin
                            rd_d     = sh_q[31:0];
                            y_d      = acc_q;
                            y_we_d   = 1'b1;
                            icc_we_d = cc_q;
                        end
                        MD_DIV: begin
                            rd_d     = sh_q[31:0];
                            icc_we_d = cc_q;
                        end
                        MD_DBZ: begin
                            rd_d  = '0;
                            dbz_d = 1'b1;
                        end
                        default: rd_d = '0;
                    endcase
                    if (icc_we_d) icc_d = {rd_d[31], rd_d == 32'd0, (kind_q == MD_DIV) && ovf_q, 1'b0};
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kind_q   <= MD_MUL;
            cnt_q    <= '0;
            sgn_q    <= 1'b0;
            cc_q     <= 1'b0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
            acc_q    <= '0;
            opnd_q   <= '0;
            sh_q     <= '0;
            rd_q     <= '0;
            y_q      <= '0;
            icc_q    <= '0;
            done_q   <= 1'b0;
            y_we_q   <= 1'b0;
            icc_we_q <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            kind_q   <= kind_d;
            cnt_q    <= cnt_d;
            sgn_q    <= sgn_d;
            cc_q     <= cc_d;
            neg_q    <= neg_d;
            ovf_q    <= ovf_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            sh_q     <= sh_d;
            rd_q     <= rd_d;
            y_q      <= y_d;
            icc_q    <= icc_d;
            done_q   <= done_d;
            y_we_q   <= y_we_d;
            icc_we_q <= icc_we_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy             = (state_q != ST_IDLE);
    assign done             = done_q;
    assign rd_out           = rd_q;
    assign y_out            = y_q;
    assign icc_out          = icc_q;
    assign y_we             = y_we_q;
    assign icc_we           = icc_we_q;
    assign division_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Randomized scoreboard bench for muldiv_seq: an arithmetic reference model pushes
// expected results at each start; a negedge monitor pops and compares on done.
module tb_muldiv_seq;

    localparam int MUL_LAT = 34;
    localparam int DIV_LAT = 66;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;
    localparam longint LMIN = 64'sh8000_0000_0000_0000;

    logic        clk, rst_n, start, flush;
    logic [5:0]  opcode;
    logic [31:0] rs1, rs2, y_in;
    logic        busy, done;
    logic [31:0] rd_out, y_out;
    logic [3:0]  icc_out;
    logic        y_we, icc_we, division_by_zero;

    typedef struct {
        logic [31:0] rd;
        logic [31:0] y;
        logic [3:0]  icc;
        logic        y_we;
        logic        icc_we;
        logic        dbz;
        int          lat;
        int          t0;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0, errors = 0, cyc = 0, pushes = 0, pops = 0, done_cnt = 0;
    logic [31:0] mdl_y;
    logic [5:0]  ops [8] = '{6'h0A, 6'h0B, 6'h1A, 6'h1B, 6'h0E, 6'h0F, 6'h1E, 6'h1F};
    logic [5:0]  ill [6] = '{6'h00, 6'h0C, 6'h1C, 6'h2A, 6'h3F, 6'h0D};

    muldiv_seq #(.MUL_STEPS(32), .DIV_STEPS(64)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .flush            (flush),
        .opcode           (opcode),
        .rs1              (rs1),
        .rs2              (rs2),
        .y_in             (y_in),
        .busy             (busy),
        .done             (done),
        .rd_out           (rd_out),
        .y_out            (y_out),
        .icc_out          (icc_out),
        .y_we             (y_we),
        .icc_we           (icc_we),
        .division_by_zero (division_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] yi, input logic [31:0] yprev);
        exp_t        e;
        logic [63:0] p, uq;
        longint      sd, sv, sq;
        logic        v, is_mul, is_div;
        logic [31:0] r;
        e.rd = '0; e.y = yprev; e.icc = '0; e.y_we = 1'b0; e.icc_we = 1'b0; e.dbz = 1'b0;
        e.lat = 1; e.t0 = 0;
        v = 1'b0; r = '0;
        is_mul = op inside {6'h0A, 6'h0B, 6'h1A, 6'h1B};
        is_div = op inside {6'h0E, 6'h0F, 6'h1E, 6'h1F};
        if (is_mul) begin
            if (op[0]) begin
                sd = longint'($signed(a));
                sv = longint'($signed(b));
                p  = sd * sv;
            end else begin
                p = {32'd0, a} * {32'd0, b};
            end
            r = p[31:0]; e.y = p[63:32]; e.y_we = 1'b1; e.lat = MUL_LAT;
        end else if (is_div && b == 32'd0) begin
            e.dbz = 1'b1;
        end else if (is_div) begin
            e.lat = DIV_LAT;
            if (!op[0]) begin
                uq = {yi, a} / {32'd0, b};
                v  = (uq > 64'h0000_0000_FFFF_FFFF);
                r  = v ? 32'hFFFF_FFFF : uq[31:0];
            end else begin
                sd = $signed({yi, a});
                sv = longint'($signed(b));
                if (sd == LMIN && sv == -1) begin
                    v = 1'b1; r = 32'h7FFF_FFFF;
                end else begin
                    sq = sd / sv;
                    if (sq > SMAX)      begin v = 1'b1; r = 32'h7FFF_FFFF; end
                    else if (sq < SMIN) begin v = 1'b1; r = 32'h8000_0000; end
                    else                r = sq[31:0];
                end
            end
        end
        e.rd = r;
        if ((is_mul || (is_div && b != 32'd0)) && op[4]) begin
            e.icc_we = 1'b1;
            e.icc    = {r[31], r == 32'd0, v, 1'b0};
        end
        return e;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n) begin
            if (done) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", {63'd0, done}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    pops++;
                    chk("latency", 64'(cyc - e.t0), 64'(e.lat));
                    chk("rd_out", {32'd0, rd_out}, {32'd0, e.rd});
                    chk("y_out", {32'd0, y_out}, {32'd0, e.y});
                    chk("y_we", {63'd0, y_we}, {63'd0, e.y_we});
                    chk("icc_we", {63'd0, icc_we}, {63'd0, e.icc_we});
                    chk("division_by_zero", {63'd0, division_by_zero}, {63'd0, e.dbz});
                    if (e.icc_we) chk("icc_out", {60'd0, icc_out}, {60'd0, e.icc});
                end
            end else begin
                chk("we_without_done", {61'd0, y_we, icc_we, division_by_zero}, 64'd0);
            end
        end
    end

    task automatic launch(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] yi);
        opcode = op; rs1 = a; rs2 = b; y_in = yi; start = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        opcode = 6'($urandom);
        rs1    = $urandom;
        rs2    = $urandom;
        y_in   = $urandom;
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] yi);
        exp_t e;
        e     = model(op, a, b, yi, mdl_y);
        e.t0  = cyc + 1;
        mdl_y = e.y;
        exp_q.push_back(e);
        pushes++;
        launch(op, a, b, yi);
        chk("busy_after_start", {63'd0, busy}, 64'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((pops != pushes || busy) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done_timeout", {63'd0, (pops != pushes)}, 64'd0);
        chk("busy_stuck", {63'd0, busy}, 64'd0);
        if (pops != pushes) begin
            exp_q.delete();
            pops = pushes;
        end
    endtask

    task automatic check_quiet(input string name, input int ncyc);
        int n0;
        n0 = done_cnt;
        repeat (ncyc) @(posedge clk);
        #1;
        chk(name, 64'(done_cnt - n0), 64'd0);
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin : stim
        logic [5:0]  op;
        logic [31:0] a, b, yi;
        rst_n = 1'b1; start = 1'b0; flush = 1'b0;
        opcode = '0; rs1 = '0; rs2 = '0; y_in = '0; mdl_y = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_rd_out", {32'd0, rd_out}, 64'd0);
        chk("rst_y_out", {32'd0, y_out}, 64'd0);
        chk("rst_icc_out", {60'd0, icc_out}, 64'd0);
        chk("rst_y_we", {63'd0, y_we}, 64'd0);
        chk("rst_icc_we", {63'd0, icc_we}, 64'd0);
        chk("rst_dbz", {63'd0, division_by_zero}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        issue(6'h1A, 32'hFFFF_FFFF, 32'd2, 32'd0);          wait_idle();
        issue(6'h0B, 32'hFFFF_FFFD, 32'd5, 32'd0);          wait_idle();
        issue(6'h0F, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);  wait_idle();
        issue(6'h1E, 32'd0, 32'd1, 32'd1);                  wait_idle();
        issue(6'h1F, 32'h0000_0000, 32'hFFFF_FFFF, 32'h8000_0000); wait_idle();
        issue(6'h0E, 32'h1234_5678, 32'd0, 32'd0);          wait_idle();
        issue(6'h2A, 32'h1111_1111, 32'd3, 32'd0);          wait_idle();

        // Reset in the middle of a multiply discards it.
        issue(6'h0B, $urandom, $urandom, 32'd0);
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_rd_out", {32'd0, rd_out}, 64'd0);
        chk("midrst_y_out", {32'd0, y_out}, 64'd0);
        exp_q.delete();
        pops  = pushes;
        mdl_y = '0;
        @(posedge clk); #1 rst_n = 1'b1;
        check_quiet("done_after_reset", 100);

        issue(6'h0A, $urandom, $urandom, 32'd0);            wait_idle();

        opcode = 6'h0A; rs1 = 32'd7; rs2 = 32'd9; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        chk("flush_start_busy", {63'd0, busy}, 64'd0);
        check_quiet("done_after_flush_start", 40);

        launch(6'h0E, $urandom, 32'd7, 32'd0);
        repeat (5) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        chk("flush_mid_busy", {63'd0, busy}, 64'd0);
        check_quiet("done_after_flush_mid", 80);

        for (int i = 0; i < 120; i++) begin
            op = ($urandom_range(0, 9) == 0) ? ill[$urandom_range(0, 5)] : ops[$urandom_range(0, 7)];
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1, 2, 3: b = b >> $urandom_range(0, 31);
                default: ;
            endcase
            case ($urandom_range(0, 3))
                0:       yi = $urandom;
                1:       yi = 32'd0;
                2:       yi = {32{a[31]}};
                default: yi = 32'($urandom_range(0, 3));
            endcase
            issue(op, a, b, yi);
            repeat (2) @(posedge clk);
            #1;
            if (busy && $urandom_range(0, 1) == 1) launch(ops[$urandom_range(0, 7)], $urandom, $urandom, $urandom);
            wait_idle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
